// File: rtl/store_buffer_pkg.sv
// Shared store opcodes and byte-enable encodings for the MEM-stage store path.
package store_buffer_pkg;

    localparam logic [5:0] op_sb = 6'h28;
    localparam logic [5:0] op_sh = 6'h29;
    localparam logic [5:0] op_sw = 6'h2B;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/store_buffer_align.sv
// Combinational store decode: byte-lane replication, byte enables and alignment check.
module store_align
    import store_buffer_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] in_,
    output logic [31:0] data,
    output logic [3:0]  be,
    output logic        is_store,
    output logic        aligned
);

    always_comb begin
        data     = '0;
        be       = '0;
        is_store = 1'b1;
        aligned  = 1'b1;
        unique case (op)
            op_sb: begin
                data = {4{in_[7:0]}};
                be   = BE_BYTE0 << addr;
            end
            op_sh: begin
                data    = {2{in_[15:0]}};
                be      = addr[1] ? BE_HALF_HI : BE_HALF_LO;
                aligned = ~addr[0];
            end
            op_sw: begin
                data    = in_;
                be      = BE_WORD;
                aligned = (addr == 2'b00);
            end
            default: begin
                is_store = 1'b0;
                aligned  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// MEM-stage store buffer: aligns sb/sh/sw requests and queues them in a FIFO
// that drains to data memory over a valid/ready handshake.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [5:0]                 op,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [31:0]                in_,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       misalign,
    output logic [ADDR_W-1:0]          badaddr,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [31:0]                mem_data,
    output logic [3:0]                 mem_be
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR_W-3:0] waddr_q [DEPTH];
    logic [31:0]       data_q  [DEPTH];
    logic [3:0]        be_q    [DEPTH];

    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              misalign_q;
    logic [ADDR_W-1:0] badaddr_q;

    logic [31:0] lane_data;
    logic [3:0]  lane_be;
    logic        is_store, aligned;
    logic        enq, deq, fault;

    store_align u_align (
        .op       (op),
        .addr     (addr[1:0]),
        .in_      (in_),
        .data     (lane_data),
        .be       (lane_be),
        .is_store (is_store),
        .aligned  (aligned)
    );

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Requests arriving while full are dropped entirely, including the fault check.
    assign enq   = wr && is_store && aligned && !full;
    assign fault = wr && is_store && !aligned && !full;
    assign deq   = !empty && mem_ready;

    always_comb begin
        wptr_d  = enq ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = deq ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (enq && !deq)
            count_d = count_q + 1'b1;
        else if (!enq && deq)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= '0;
                data_q[i]  <= '0;
                be_q[i]    <= '0;
            end
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
            badaddr_q  <= '0;
        end else begin
            if (enq) begin
                waddr_q[wptr_q] <= addr[ADDR_W-1:2];
                data_q[wptr_q]  <= lane_data;
                be_q[wptr_q]    <= lane_be;
            end
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            misalign_q <= fault;
            if (fault)
                badaddr_q <= addr;
        end
    end

    assign count     = count_q;
    assign misalign  = misalign_q;
    assign badaddr   = badaddr_q;
    assign mem_valid = !empty;
    assign mem_addr  = {waddr_q[rptr_q], 2'b00};
    assign mem_data  = data_q[rptr_q];
    assign mem_be    = be_q[rptr_q];

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a queue-based reference model checked every cycle.
module tb_store_buffer;

    localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B, LW = 6'h23;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0, mem_ready = 1'b0;
    logic [5:0]  op = '0;
    logic [31:0] addr = '0, in_ = '0;
    logic        full, empty, misalign, mem_valid;
    logic [2:0]  count;
    logic [31:0] badaddr, mem_addr, mem_data;
    logic [3:0]  mem_be;

    int tests = 0;
    int fails = 0;

    store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .wr(wr), .op(op), .addr(addr), .in_(in_),
        .full(full), .empty(empty), .count(count), .misalign(misalign),
        .badaddr(badaddr), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_be(mem_be)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    ent_t        q[$];
    logic        m_mis = 1'b0;
    logic [31:0] m_bad = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural rules applied to a plain queue.
    always @(posedge clk or posedge rst) begin
        bit   st, al, full_m, acc, deq;
        ent_t e;
        if (rst) begin
            q.delete();
            m_mis = 1'b0;
            m_bad = '0;
        end else begin
            st     = (op == SB) || (op == SH) || (op == SW);
            al     = (op == SB) || (op == SH && addr % 2 == 0) || (op == SW && addr % 4 == 0);
            full_m = (q.size() == 4);
            deq    = (q.size() > 0) && mem_ready;
            acc    = wr && st && al && !full_m;
            m_mis  = wr && st && !al && !full_m;
            if (m_mis) m_bad = addr;
            e.a = addr & 32'hFFFF_FFFC;
            if (op == SB) begin
                e.d  = (in_ & 32'hFF) * 32'h0101_0101;
                e.be = 4'(1 << (addr % 4));
            end else if (op == SH) begin
                e.d  = (in_ & 32'hFFFF) * 32'h0001_0001;
                e.be = ((addr / 2) % 2 == 1) ? 4'd12 : 4'd3;
            end else begin
                e.d  = in_;
                e.be = 4'd15;
            end
            if (deq) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("count", 32'(count), 32'(q.size()));
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("full", 32'(full), 32'(q.size() == 4));
            chk("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
            chk("misalign", 32'(misalign), 32'(m_mis));
            chk("badaddr", badaddr, m_bad);
            if (q.size() != 0) begin
                chk("mem_addr", mem_addr, q[0].a);
                chk("mem_data", mem_data, q[0].d);
                chk("mem_be", 32'(mem_be), 32'(q[0].be));
            end
        end
    end

    task automatic step(input logic w, input logic [5:0] o, input logic [31:0] a,
                        input logic [31:0] d, input logic r);
        wr = w; op = o; addr = a; in_ = d; mem_ready = r;
        @(negedge clk);
    endtask

    typedef struct { logic [5:0] o; logic [31:0] a; logic [31:0] d; } vec_t;
    vec_t vecs[6] = '{
        '{SB, 32'h0000_0040, 32'h1234_5677},
        '{SB, 32'h0000_0041, 32'h0000_00C3},
        '{SH, 32'h0000_0052, 32'hDEAD_BEEF},
        '{SH, 32'h0000_0011, 32'h0000_5555},
        '{SW, 32'h0000_0060, 32'hCAFE_F00D},
        '{SW, 32'h0000_0063, 32'h0BAD_0BAD}
    };

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_badaddr", badaddr, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        rst = 1'b0;
        step(0, 0, 0, 0, 1);

        step(1, SB, 32'h1003, 32'h0000_00A5, 1);
        chk("sb_valid", 32'(mem_valid), 32'd1);
        chk("sb_addr", mem_addr, 32'h1000);
        chk("sb_data", mem_data, 32'hA5A5_A5A5);
        chk("sb_be", 32'(mem_be), 32'b1000);
        step(0, 0, 0, 0, 1);
        chk("sb_drained", 32'(count), 32'd0);

        step(1, SW, 32'h2002, 32'h1111_1111, 1);
        chk("mis_pulse", 32'(misalign), 32'd1);
        chk("mis_badaddr", badaddr, 32'h2002);
        chk("mis_count", 32'(count), 32'd0);
        step(0, 0, 0, 0, 1);
        chk("mis_one_cycle", 32'(misalign), 32'd0);
        chk("mis_hold", badaddr, 32'h2002);

        for (int i = 0; i < 5; i++)
            step(1, SW, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 0);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_head", mem_data, 32'hA000_0000);
        step(1, SW, 32'h110, 32'hA000_0004, 1);
        chk("full_refuse", 32'(count), 32'd3);
        step(1, SW, 32'h110, 32'hA000_0004, 1);
        chk("fifth_accept", 32'(count), 32'd3);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        chk("drain_empty", 32'(empty), 32'd1);

        step(1, SW, 32'h200, 32'h0000_0200, 0);
        step(1, SW, 32'h204, 32'h0000_0204, 0);
        chk("pre_sim_count", 32'(count), 32'd2);
        step(1, SH, 32'h10, 32'h0000_1234, 1);
        chk("sim_count", 32'(count), 32'd2);
        step(0, 0, 0, 0, 1);
        chk("sim_tail_addr", mem_addr, 32'h10);
        chk("sim_tail_data", mem_data, 32'h1234_1234);
        chk("sim_tail_be", 32'(mem_be), 32'b0011);
        step(0, 0, 0, 0, 1);

        foreach (vecs[i]) step(1, vecs[i].o, vecs[i].a, vecs[i].d, 1);
        step(0, 0, 0, 0, 1);

        step(1, SW, 32'h300, 32'h0000_0300, 0);
        step(1, LW, 32'h3003, 32'hFFFF_FFFF, 0);
        chk("lw_count", 32'(count), 32'd1);
        chk("lw_misalign", 32'(misalign), 32'd0);
        chk("lw_addr", mem_addr, 32'h300);

        step(1, SB, 32'h305, 32'h0000_0005, 0);
        step(1, SH, 32'h306, 32'h0000_0006, 0);
        wr = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_count", 32'(count), 32'd0);
        chk("rst_mid_valid", 32'(mem_valid), 32'd0);
        chk("rst_mid_empty", 32'(empty), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step(0, 0, 0, 0, 1);
        chk("post_rst_idle", 32'(mem_valid), 32'd0);
        step(1, SW, 32'h400, 32'h0000_0400, 0);
        chk("post_rst_new", 32'(mem_valid), 32'd1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
